ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
Parametrised control-word pipeline that carries decoded control bits from decode through NSTAGES downstream stages. It generalises the fixed E/M/W control registers into a single block with a configurable depth and width, and a per-stage field mask. Each stage has a valid bit, stall and flush inputs, automatic stall back-propagation and automatic bubble insertion. It sits beside the decoder, and each stage's tap feeds that stage's datapath.

Parameters:
CW, 16, control word width in bits.
NSTAGES, 3, number of pipeline stages after decode (stage 0 = E, 1 = M, 2 = W at the default).
STAGE_MASK, all ones ({NSTAGES*CW{1'b1}}), per-stage field keep mask. Slice [k*CW +: CW] applies to stage k. A 0 bit forces that field to 0 in stage k and all later stages.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous active-high reset.
in_ctrl  input  CW  control word from decode.
in_valid  input  1  in_ctrl holds a real instruction.
in_ready  output  1  stage 0 will load this cycle (= ~stall_eff[0]); combinational.
stall  input  NSTAGES  per-stage stall request.
flush  input  NSTAGES  per-stage flush request.
ctrl_o  output  NSTAGES*CW  registered control word of stage k at [k*CW +: CW].
valid_o  output  NSTAGES  registered valid of stage k.
stall_eff_o  output  NSTAGES  effective stall vector, for the hazard unit and debug; combinational.

Behaviour:
- Reset: stage registers update only on the rising edge of clk.
  - rst=1 at an edge forces every ctrl_o to 0 and every valid_o to 0.
  - rst overrides stall and flush.
  - Reset mid-stream discards all in-flight words; no partial state survives.
- Effective stall: stall_eff[k] = stall[k] | stall_eff[k+1]. A downstream stall freezes all upstream stages. stall_eff[NSTAGES-1] = stall[NSTAGES-1].
- Stage k update, in priority order, at each edge with rst=0:
  1. flush[k]=1: ctrl_k <= 0, valid_k <= 0. Flush beats stall.
  2. stall_eff[k]=1: hold ctrl_k and valid_k.
  3. k>0 and stall_eff[k-1]=1: insert a bubble, ctrl_k <= 0, valid_k <= 0.
  4. Otherwise load from upstream. Source for k=0 is in_ctrl/in_valid; for k>0 it is ctrl_{k-1}/valid_{k-1}.
     - ctrl_k <= src & mask_k & mask_{k-1} & ... & mask_0 (cumulative AND of masks). Computed once per stage via the chained mask.
     - ctrl_k <= 0 if the source valid = 0.
     - valid_k <= source valid.
- Stage 0 loads only when in_ready=1. The upstream decode register must hold its word while in_ready=0. No word is lost or duplicated across any stall pattern.
- Latency: a word accepted at edge t is visible on stage k outputs after edge t+k, i.e. k+1 edges after presentation, when no stalls occur.
- Invariant: valid_k=0 implies ctrl_k=0. Verification asserts this every cycle.
- Simultaneous flush[k] and stall[k-1]: stage k is cleared, and upstream holds per its own stall_eff.
- Flush of a stalled stage clears it; the stage then stays stalled, holding the bubble.
- NSTAGES=1 is legal: rules 1, 2 and 4 only.

Optional Feature:
Macro CTRL_PIPE_PERF_EN.
- Defined: adds two ports.
  - retire_cnt (output, 32): increments every edge where the last stage is not stalled, not flushed, and valid_{NSTAGES-1}=1 (i.e. the word leaves).
  - bubble_cnt (output, 32): increments every edge where any stage takes rule 3.
  - Both reset to 0 and wrap from 0xFFFFFFFF to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with stall=3'b111 and flush=0 -> ctrl_o=0, valid_o=0; after release with stall=0, in_ready=1.
2. Stream (defaults): present 0x0001, 0x0002, 0x0003 with in_valid=1 on consecutive cycles -> stage2 shows 0x0001, 0x0002, 0x0003 with valid=1 on edges 3, 4, 5; no gaps.
3. Stall propagation: stream 0x0011..0x0015 and assert stall[1] for 2 cycles while 0x0012 is in stage 1 -> in_ready=0 and stages 0/1 hold for both cycles; stage 2 gets bubbles (valid=0, ctrl=0) twice; stage 2 then outputs 0x0011, bubble, bubble, 0x0012..0x0015 in order.
4. Flush vs stall: with stage1=0x00AA valid, assert flush[1]=1 and stall[1]=1 together -> stage1 becomes 0/valid 0 next edge; stage0 holds its word.
5. Masking: STAGE_MASK stage1 slice=0xFFFF, stage2 slice=0x00FF, present 0xABCD -> stage0 0xABCD, stage1 0xABCD, stage2 0x00CD.
6. Perf (CTRL_PIPE_PERF_EN): run scenario 3 -> retire_cnt=5, bubble_cnt=2. With the macro undefined, the bench compiles without those ports and scenario 3 results are unchanged.

Source files
------------

// File: rtl/ctrl_pipe.sv
// Control-word pipeline: NSTAGES registered stages with per-stage valid, stall/flush,
// stall back-propagation, bubble insertion and cumulative field masking.
// Optional retire/bubble counters are enabled with the macro CTRL_PIPE_PERF_EN.
module ctrl_pipe #(
    parameter int CW      = 16,
    parameter int NSTAGES = 3,
    parameter logic [NSTAGES*CW-1:0] STAGE_MASK = {(NSTAGES*CW){1'b1}}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CW-1:0]           in_ctrl,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NSTAGES-1:0]      stall,
    input  logic [NSTAGES-1:0]      flush,
    output logic [NSTAGES*CW-1:0]   ctrl_o,
    output logic [NSTAGES-1:0]      valid_o,
    output logic [NSTAGES-1:0]      stall_eff_o
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [31:0]             retire_cnt,
    output logic [31:0]             bubble_cnt
`endif
);

    // Stage k keeps only the bits that survived every mask up to and including k.
    function automatic logic [NSTAGES*CW-1:0] cum_masks();
        logic [NSTAGES*CW-1:0] res;
        logic [CW-1:0]         acc;
        res = {(NSTAGES*CW){1'b0}};
        acc = {CW{1'b1}};
        for (int j = 0; j < NSTAGES; j++) begin
            acc = acc & STAGE_MASK[j*CW +: CW];
            res[j*CW +: CW] = acc;
        end
        return res;
    endfunction

    localparam logic [NSTAGES*CW-1:0] KEEP = cum_masks();

    logic [NSTAGES*CW-1:0] ctrl_r;
    logic [NSTAGES-1:0]    valid_r;
    logic [NSTAGES*CW-1:0] ctrl_nxt_s;
    logic [NSTAGES-1:0]    valid_nxt_s;
    logic [NSTAGES-1:0]    stall_eff_s;
    logic [CW-1:0]         src_ctrl_s;
    logic                  src_valid_s;
    logic                  up_stall_s;
`ifdef CTRL_PIPE_PERF_EN
    logic [NSTAGES-1:0]    bubble_s;
`endif

    // Effective stall: a stage is frozen if it or any later stage stalls.
    always_comb begin
        stall_eff_s = {NSTAGES{1'b0}};
        for (int k = 0; k < NSTAGES; k++) begin
            stall_eff_s[k] = |(stall >> k);
        end
    end

    // Next-state selection per stage: flush, hold, bubble, then load.
    always_comb begin
        ctrl_nxt_s  = ctrl_r;
        valid_nxt_s = valid_r;
        src_ctrl_s  = {CW{1'b0}};
        src_valid_s = 1'b0;
        up_stall_s  = 1'b0;
`ifdef CTRL_PIPE_PERF_EN
        bubble_s    = {NSTAGES{1'b0}};
`endif
        for (int k = 0; k < NSTAGES; k++) begin
            if (k == 0) begin
                src_ctrl_s  = in_ctrl;
                src_valid_s = in_valid;
                up_stall_s  = 1'b0;
            end else begin
                src_ctrl_s  = ctrl_r[(k-1)*CW +: CW];
                src_valid_s = valid_r[k-1];
                up_stall_s  = stall_eff_s[k-1];
            end
            if (flush[k]) begin
                ctrl_nxt_s[k*CW +: CW] = {CW{1'b0}};
                valid_nxt_s[k]         = 1'b0;
            end else if (stall_eff_s[k]) begin
                ctrl_nxt_s[k*CW +: CW] = ctrl_r[k*CW +: CW];
                valid_nxt_s[k]         = valid_r[k];
            end else if (up_stall_s) begin
                ctrl_nxt_s[k*CW +: CW] = {CW{1'b0}};
                valid_nxt_s[k]         = 1'b0;
`ifdef CTRL_PIPE_PERF_EN
                bubble_s[k]            = 1'b1;
`endif
            end else begin
                // Invalid words are zeroed so valid=0 always implies ctrl=0.
                ctrl_nxt_s[k*CW +: CW] = src_valid_s ? (src_ctrl_s & KEEP[k*CW +: CW])
                                                     : {CW{1'b0}};
                valid_nxt_s[k]         = src_valid_s;
            end
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_r  <= {(NSTAGES*CW){1'b0}};
            valid_r <= {NSTAGES{1'b0}};
        end else begin
            ctrl_r  <= ctrl_nxt_s;
            valid_r <= valid_nxt_s;
        end
    end

`ifdef CTRL_PIPE_PERF_EN
    logic retire_fire_s;
    assign retire_fire_s = valid_r[NSTAGES-1] & ~stall_eff_s[NSTAGES-1] & ~flush[NSTAGES-1];

    // Wrapping performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt <= 32'd0;
            bubble_cnt <= 32'd0;
        end else begin
            retire_cnt <= retire_fire_s ? retire_cnt + 32'd1 : retire_cnt;
            bubble_cnt <= (|bubble_s)   ? bubble_cnt + 32'd1 : bubble_cnt;
        end
    end
`endif

    assign in_ready    = ~stall_eff_s[0];
    assign stall_eff_o = stall_eff_s;
    assign ctrl_o      = ctrl_r;
    assign valid_o     = valid_r;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed self-checking bench for ctrl_pipe: default-mask instance plus a masked instance
// sharing the same stimulus. Counter checks compile in only with CTRL_PIPE_PERF_EN.
module tb_ctrl_pipe;
    localparam int CW = 16;
    localparam int NS = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [CW-1:0]   in_ctrl;
    logic            in_valid;
    logic [NS-1:0]   stall;
    logic [NS-1:0]   flush;
    logic            in_ready,    m_in_ready;
    logic [NS*CW-1:0] ctrl_o,     m_ctrl_o;
    logic [NS-1:0]   valid_o,     m_valid_o;
    logic [NS-1:0]   stall_eff_o, m_stall_eff_o;
`ifdef CTRL_PIPE_PERF_EN
    logic [31:0]     retire_cnt, bubble_cnt, m_retire_cnt, m_bubble_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ctrl_pipe #(.CW(CW), .NSTAGES(NS)) dut (
        .clk(clk), .rst(rst), .in_ctrl(in_ctrl), .in_valid(in_valid), .in_ready(in_ready),
        .stall(stall), .flush(flush), .ctrl_o(ctrl_o), .valid_o(valid_o),
        .stall_eff_o(stall_eff_o)
`ifdef CTRL_PIPE_PERF_EN
        , .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    ctrl_pipe #(.CW(CW), .NSTAGES(NS), .STAGE_MASK(48'h00FF_FFFF_FFFF)) u_mask (
        .clk(clk), .rst(rst), .in_ctrl(in_ctrl), .in_valid(in_valid), .in_ready(m_in_ready),
        .stall(stall), .flush(flush), .ctrl_o(m_ctrl_o), .valid_o(m_valid_o),
        .stall_eff_o(m_stall_eff_o)
`ifdef CTRL_PIPE_PERF_EN
        , .retire_cnt(m_retire_cnt), .bubble_cnt(m_bubble_cnt)
`endif
    );

    function automatic logic [CW-1:0] sc(input logic [NS*CW-1:0] v, input int k);
        return v[k*CW +: CW];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then check the valid=0 -> ctrl=0 invariant on both instances.
    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < NS; k++) begin
            chk("inv_main", {63'd0, (!valid_o[k] && sc(ctrl_o, k) != 16'h0)}, 64'd0);
            chk("inv_mask", {63'd0, (!m_valid_o[k] && sc(m_ctrl_o, k) != 16'h0)}, 64'd0);
        end
    endtask

    logic [15:0] words   [5]  = '{16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0015};
    logic        exp_rdy [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] exp_s2  [10] = '{16'h0, 16'h0, 16'h0011, 16'h0, 16'h0, 16'h0012,
                                  16'h0013, 16'h0014, 16'h0015, 16'h0};
    logic        exp_v2  [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        int  idx;
        logic acc;
        // Reset with all stages stalled.
        rst = 1'b1; stall = 3'b111; flush = 3'b000; in_valid = 1'b0; in_ctrl = 16'h0;
        step(); step();
        chk("rst_ctrl", {16'd0, ctrl_o}, 64'd0);
        chk("rst_valid", {61'd0, valid_o}, 64'd0);
        chk("rst_ready_stalled", {63'd0, in_ready}, 64'd0);
        rst = 1'b0; stall = 3'b000;
        #1;
        chk("ready_after_rst", {63'd0, in_ready}, 64'd1);

        // Back-to-back stream: stage 2 shows 1,2,3 on edges 3,4,5.
        for (int i = 1; i <= 5; i++) begin
            in_valid = (i <= 3);
            in_ctrl  = (i <= 3) ? 16'(i) : 16'h0;
            step();
            if (i == 1) chk("stream_s0", {48'd0, sc(ctrl_o, 0)}, 64'h0001);
            if (i >= 3) begin
                chk("stream_s2", {48'd0, sc(ctrl_o, 2)}, 64'(i - 2));
                chk("stream_v2", {63'd0, valid_o[2]}, 64'd1);
            end
        end

        rst = 1'b1; in_valid = 1'b0; step(); rst = 1'b0;
`ifdef CTRL_PIPE_PERF_EN
        chk("perf_rst_retire", {32'd0, retire_cnt}, 64'd0);
        chk("perf_rst_bubble", {32'd0, bubble_cnt}, 64'd0);
`endif

        // Stall stage 1 for two cycles while 0x0012 sits in it.
        idx = 0;
        for (int c = 1; c <= 10; c++) begin
            stall = (c == 4 || c == 5) ? 3'b010 : 3'b000;
            if (idx < 5) begin
                in_valid = 1'b1; in_ctrl = words[idx];
            end else begin
                in_valid = 1'b0; in_ctrl = 16'h0;
            end
            #1;
            chk("stall_ready", {63'd0, in_ready}, {63'd0, exp_rdy[c-1]});
            acc = in_ready && in_valid;
            step();
            if (acc) idx++;
            chk("stall_s2", {48'd0, sc(ctrl_o, 2)}, {48'd0, exp_s2[c-1]});
            chk("stall_v2", {63'd0, valid_o[2]}, {63'd0, exp_v2[c-1]});
            if (c == 4 || c == 5) begin
                chk("stall_hold_s0", {48'd0, sc(ctrl_o, 0)}, 64'h0013);
                chk("stall_hold_s1", {48'd0, sc(ctrl_o, 1)}, 64'h0012);
                chk("stall_hold_v", {61'd0, valid_o[1:0], 1'b0}, 64'h6);
            end
        end
`ifdef CTRL_PIPE_PERF_EN
        chk("perf_retire", {32'd0, retire_cnt}, 64'd5);
        chk("perf_bubble", {32'd0, bubble_cnt}, 64'd2);
`endif

        // Flush and stall on stage 1 at once.
        stall = 3'b000; flush = 3'b000;
        in_valid = 1'b1; in_ctrl = 16'h00AA; step();
        in_ctrl = 16'h00BB; step();
        chk("fs_pre_s1", {48'd0, sc(ctrl_o, 1)}, 64'h00AA);
        flush = 3'b010; stall = 3'b010; in_ctrl = 16'h00CC;
        #1;
        chk("fs_ready", {63'd0, in_ready}, 64'd0);
        chk("fs_stall_eff", {61'd0, stall_eff_o}, 64'h3);
        step();
        chk("fs_s1_ctrl", {48'd0, sc(ctrl_o, 1)}, 64'h0);
        chk("fs_s1_valid", {63'd0, valid_o[1]}, 64'd0);
        chk("fs_s0_hold", {48'd0, sc(ctrl_o, 0)}, 64'h00BB);
        chk("fs_s0_valid", {63'd0, valid_o[0]}, 64'd1);
        flush = 3'b000;
        step();
        chk("fs_bubble_held", {62'd0, valid_o[1], (sc(ctrl_o, 1) != 16'h0)}, 64'd0);
        chk("fs_s0_still", {48'd0, sc(ctrl_o, 0)}, 64'h00BB);
        stall = 3'b000;
        step();
        chk("fs_resume_s0", {48'd0, sc(ctrl_o, 0)}, 64'h00CC);
        chk("fs_resume_s1", {48'd0, sc(ctrl_o, 1)}, 64'h00BB);
        in_valid = 1'b0; in_ctrl = 16'h0;
        step(); step(); step();

        // Cumulative masking on the masked instance.
        in_valid = 1'b1; in_ctrl = 16'hABCD; step();
        chk("mask_s0", {48'd0, sc(m_ctrl_o, 0)}, 64'hABCD);
        in_valid = 1'b0; in_ctrl = 16'hFFFF; step();
        chk("mask_s1", {48'd0, sc(m_ctrl_o, 1)}, 64'hABCD);
        chk("invalid_in_zero", {48'd0, sc(m_ctrl_o, 0)}, 64'h0);
        step();
        chk("mask_s2", {48'd0, sc(m_ctrl_o, 2)}, 64'h00CD);
        chk("mask_v2", {63'd0, m_valid_o[2]}, 64'd1);
        chk("nomask_s2", {48'd0, sc(ctrl_o, 2)}, 64'hABCD);

        // Reset mid-stream overrides stall and flush.
        in_valid = 1'b1; in_ctrl = 16'h1234; step(); step();
        rst = 1'b1; stall = 3'b111; flush = 3'b111; step();
        chk("midrst_ctrl", {16'd0, ctrl_o}, 64'd0);
        chk("midrst_valid", {61'd0, valid_o}, 64'd0);
`ifdef CTRL_PIPE_PERF_EN
        chk("midrst_retire", {32'd0, retire_cnt}, 64'd0);
`endif
        rst = 1'b0; stall = 3'b000; flush = 3'b000; in_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
